// File: rtl/qspi_arbiter.sv
// qspi_arbiter: two-port (CPU/XIP, loader) round-robin arbiter in front of one QSPI controller
// Ports: m0_*/m1_* requester handshakes (valid held until a one-cycle ready pulse),
//   s_* registered request to / completion from the QSPI controller,
//   grant one-hot owner (0 when idle), timeout_err sticky abort flag.
// Config: define QSPI_ARB_TIMEOUT_EN to abort a BUSY transaction after TIMEOUT_CYCLES
//   busy cycles without s_ready; otherwise BUSY waits indefinitely and timeout_err is 0.
module qspi_arbiter #(
  parameter int ADDR_W         = 24,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_valid,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_ready,
  output logic [31:0]       m0_rdata,
  input  logic              m1_valid,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_ready,
  output logic [31:0]       m1_rdata,
  output logic              s_valid,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [31:0]       s_wdata,
  input  logic              s_ready,
  input  logic [31:0]       s_rdata,
  output logic [1:0]        grant,
  output logic              timeout_err
);
`ifdef QSPI_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_d, cnt_q;
  logic          err_d, err_q;
`else
  typedef enum logic {IDLE, BUSY} state_t;
`endif
  state_t            state_d, state_q;
  logic              own_d, own_q, last_d, last_q, we_d, we_q, armed_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [31:0]       wdata_d, wdata_q, rdata;
  logic              pick, abort, done;
  // On a tie the port that was not served last wins
  assign pick  = (m0_valid && m1_valid) ? ~last_q : m1_valid;
`ifdef QSPI_ARB_TIMEOUT_EN
  assign abort       = state_q == ABORT;
  assign timeout_err = err_q;
`else
  assign abort       = 1'b0;
  assign timeout_err = 1'b0;
`endif
  assign done  = (state_q == BUSY && s_ready) || abort;
  assign rdata = abort ? 32'hFFFF_FFFF : s_rdata;
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef QSPI_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    if (state_q == IDLE) begin
      // armed_q holds off arbitration for the first edge after reset release
      if (armed_q && (m0_valid || m1_valid)) begin
        state_d = BUSY;
        own_d   = pick;
        we_d    = pick ? m1_we    : m0_we;
        addr_d  = pick ? m1_addr  : m0_addr;
        wdata_d = pick ? m1_wdata : m0_wdata;
`ifdef QSPI_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
    end
`ifdef QSPI_ARB_TIMEOUT_EN
    else if (state_q == ABORT) begin
      err_d   = 1'b1;
      last_d  = own_q;
      state_d = IDLE;
    end
`endif
    else begin
      if (s_ready) begin
        last_d  = own_q;
        state_d = IDLE;
      end
`ifdef QSPI_ARB_TIMEOUT_EN
      else begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == CW'(TIMEOUT_CYCLES)) state_d = ABORT;
      end
`endif
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      own_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      armed_q <= 1'b0;
`ifdef QSPI_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      armed_q <= 1'b1;
`ifdef QSPI_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end
  assign s_valid  = state_q == BUSY;
  assign s_we     = we_q;
  assign s_addr   = addr_q;
  assign s_wdata  = wdata_q;
  assign grant    = (state_q == IDLE) ? 2'b00 : (own_q ? 2'b10 : 2'b01);
  assign m0_ready = done && !own_q;
  assign m1_ready = done && own_q;
  assign m0_rdata = m0_ready ? rdata : 32'h0;
  assign m1_rdata = m1_ready ? rdata : 32'h0;
endmodule

// File: tb/tb_qspi_arbiter.sv
// tb_qspi_arbiter: randomized scoreboard bench for qspi_arbiter with a reference arbitration model
module tb_qspi_arbiter;
  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  v, we, pv;
  logic [23:0] ad [2];
  logic [31:0] wd [2];
  logic        m0_ready, m1_ready, s_valid, s_we, s_ready, timeout_err;
  logic [31:0] m0_rdata, m1_rdata, s_wdata, s_rdata;
  logic [23:0] s_addr;
  logic [1:0]  grant;
  typedef struct {bit port; logic [31:0] data;} exp_t;
  exp_t exp_q[$];
  int   tests = 0, fails = 0, fix_lat = -1, cnt = 0;
  bit   last = 1'b1, hold = 1'b0, active = 1'b0, sent = 1'b0, owner = 1'b0;

  qspi_arbiter #(.ADDR_W(24), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(v[0]), .m0_we(we[0]), .m0_addr(ad[0]), .m0_wdata(wd[0]),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(v[1]), .m1_we(we[1]), .m1_addr(ad[1]), .m1_wdata(wd[1]),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata), .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic wait_ready(input int p);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (p == 1 ? m1_ready : m0_ready) break;
    end
    if (k == 300) begin
      tests++;
      fails++;
      $display("FAIL wait_ready%0d: got no ready expected ready within 300 cycles", p);
    end
  endtask

  task automatic drv(input int p, input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, maxgap)) begin
        v[p] = 1'b0;
        @(posedge clk); #1;
      end
      v[p]  = 1'b1;
      we[p] = 1'($urandom_range(0, 1));
      ad[p] = 24'($urandom);
      wd[p] = $urandom;
      wait_ready(p);
      @(posedge clk); #1;
    end
    v[p] = 1'b0;
  endtask

  // Request lines as the DUT will sample them at the next rising edge
  always @(negedge clk) pv <= v;

  // QSPI controller model: decides the expected owner of each new transaction
  // from the sampled requests and the last served port, then completes it
  initial begin
    s_ready = 1'b0;
    s_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (!resetn) begin
        active = 1'b0; sent = 1'b0; s_ready = 1'b0;
        continue;
      end
      s_ready = 1'b0;
      if (sent) begin
        chk("idle_after_ready", s_valid, 0);
        active = 1'b0;
        sent   = 1'b0;
      end
      if (active && !s_valid) active = 1'b0;
      if (!active && s_valid) begin
        if (pv == 2'b00) begin
          tests++; fails++;
          $display("FAIL spurious_start: got s_valid=1 expected no request pending");
        end
        owner  = (pv == 2'b11) ? !last : pv[1];
        active = 1'b1;
        cnt    = fix_lat >= 0 ? fix_lat : $urandom_range(0, 6);
`ifdef QSPI_ARB_TIMEOUT_EN
        if (hold) begin
          exp_q.push_back('{owner, 32'hFFFF_FFFF});
          last = owner;
        end
`endif
      end
      if (active) begin
        chk("grant", grant, owner ? 2 : 1);
        chk("s_we", s_we, we[owner]);
        chk("s_addr", s_addr, ad[owner]);
        chk("s_wdata", s_wdata, wd[owner]);
        if (!hold) begin
          if (cnt == 0) begin
            s_ready = 1'b1;
            s_rdata = fix_lat >= 0 ? 32'h1234_5678 : $urandom;
            exp_q.push_back('{owner, s_rdata});
            last = owner;
            sent = 1'b1;
          end else cnt--;
        end
      end else begin
        s_ready = ($urandom_range(0, 3) == 0);
        s_rdata = $urandom;
      end
    end
  end

  // Monitor: every ready pulse must match the oldest expected completion
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (resetn) begin
      if (m0_ready || m1_ready) begin
        chk("single_ready", {31'b0, m0_ready & m1_ready}, 0);
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_ready: got m0_ready=%b m1_ready=%b expected none", m0_ready, m1_ready);
        end else begin
          e = exp_q.pop_front();
          chk("ready_port", m1_ready, e.port);
          chk("ready_rdata", e.port ? m1_rdata : m0_rdata, e.data);
        end
      end else chk("rdata_zero", m0_rdata | m1_rdata, 0);
`ifndef QSPI_ARB_TIMEOUT_EN
      chk("timeout_err_tied", timeout_err, 0);
`endif
    end
  end

  initial begin
    resetn = 1'b0;
    v = '0; we = '0;
    ad[0] = '0; ad[1] = '0; wd[0] = '0; wd[1] = '0;
    #1;
    chk("rst_s_valid", s_valid, 0);
    chk("rst_s_we", s_we, 0);
    chk("rst_s_addr", s_addr, 0);
    chk("rst_s_wdata", s_wdata, 0);
    chk("rst_grant", grant, 0);
    chk("rst_ready", {m1_ready, m0_ready}, 0);
    chk("rst_timeout_err", timeout_err, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(posedge clk); #1;
    fork drv(0, 1, 0); drv(1, 1, 0); join
    v[0] = 1'b1; we[0] = 1'b0; ad[0] = 24'h000100; wd[0] = 32'h0;
    fix_lat = 8;
    @(posedge clk); #1;
    chk("latency1_s_valid", s_valid, 1);
    chk("latency1_grant", grant, 1);
    wait_ready(0);
    chk("read_rdata", m0_rdata, 32'h1234_5678);
    @(posedge clk); #1;
    v[0] = 1'b0;
    fix_lat = -1;
    chk("grant_idle", grant, 0);
    fork drv(0, 3, 0); drv(1, 3, 0); join
    fork drv(0, 40, 3); drv(1, 40, 3); join
    v[1] = 1'b1; we[1] = 1'b1; ad[1] = 24'h0000F0; wd[1] = 32'hA5A5_A5A5;
    wait_ready(1);
    @(posedge clk); #1;
    v[1] = 1'b0;
    repeat (2) @(posedge clk); #1;
    hold = 1'b1;
    v[0] = 1'b1; we[0] = 1'b1; ad[0] = 24'h123456; wd[0] = $urandom;
    @(posedge clk); #1;
    chk("busy_before_reset", s_valid, 1);
    repeat (2) @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    chk("async_rst_s_valid", s_valid, 0);
    chk("async_rst_grant", grant, 0);
    chk("async_rst_ready", {m1_ready, m0_ready}, 0);
    chk("async_rst_s_addr", s_addr, 0);
    exp_q.delete();
    last = 1'b1;
    hold = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("no_grant_first_edge", s_valid, 0);
    @(posedge clk); #1;
    chk("grant_second_edge", s_valid, 1);
    wait_ready(0);
    @(posedge clk); #1;
    v[0] = 1'b0;
`ifdef QSPI_ARB_TIMEOUT_EN
    repeat (2) @(posedge clk); #1;
    hold = 1'b1;
    v[0] = 1'b1; we[0] = 1'b0; ad[0] = 24'h000200;
    wait_ready(0);
    @(posedge clk); #1;
    v[0] = 1'b0;
    hold = 1'b0;
    chk("timeout_err_set", timeout_err, 1);
    repeat (5) @(posedge clk); #1;
    chk("timeout_err_sticky", timeout_err, 1);
`endif
    repeat (3) @(posedge clk); #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
